tdm_demux2: RTL and testbench
=============================

// Module: tdm_demux2
// PURPOSE
//  Receive end of a 2-channel time-division link: one serial stream carries
//  alternating channel-A / channel-B samples, the slot order that a 2:1 mux
//  produces when its select toggles every beat. Sync-tagged A slots give frame
//  alignment. The block re-splits the stream into two registered channel
//  outputs with strobes, and tracks lock and sync errors. Sits after the link
//  input and feeds per-channel consumers.
// PARAMETERS
//  WIDTH    1  sample width in bits
//  TIMEOUT  8  idle cycles allowed in SLOT_B before lock is dropped (2..255)
//  ERRW     8  width of the saturating sync-error counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_data    in   WIDTH  serial sample
//  in_valid   in   1      in_data holds a sample this cycle
//  in_sync    in   1      sample is a channel-A (frame start) slot; ignored if !in_valid
//  out_a      out  WIDTH  last accepted channel-A sample (held)
//  out_b      out  WIDTH  last accepted channel-B sample (held)
//  a_valid    out  1      1-cycle pulse: out_a updated
//  b_valid    out  1      1-cycle pulse: out_b updated
//  pair_valid out  1      1-cycle pulse: {out_a,out_b} are one frame (same cycle as b_valid)
//  locked     out  1      level: frame alignment held
//  sync_err   out  1      1-cycle pulse: slot/sync mismatch detected
//  err_cnt    out  ERRW   saturating count of sync_err pulses
// BEHAVIOUR
//  - Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
//  - Reset: state=HUNT. All outputs are 0: out_a, out_b, strobes, locked,
//    err_cnt. The idle counter is also 0.
//  - All outputs are registered. Latency is 1 cycle from the accepted beat to
//    the updated data and strobe. There is no backpressure: every in_valid
//    beat is consumed.
//  - FSM states: HUNT, SLOT_B (expect B), SLOT_A (expect A).
//  - HUNT: valid & sync -> out_a<=data, a_valid, go SLOT_B. Valid & !sync ->
//    discard, no error.
//  - SLOT_B: valid & !sync -> out_b<=data, b_valid, pair_valid, locked<=1,
//    go SLOT_A. Valid & sync -> early sync: sync_err, treat the beat as a new
//    A (out_a<=data, a_valid), stay in SLOT_B, locked<=0.
//  - SLOT_A: valid & sync -> out_a<=data, a_valid, go SLOT_B. Valid & !sync ->
//    missed sync: sync_err, discard the beat, locked<=0, go HUNT.
//  - Idle counter: clears on any valid beat and counts !in_valid cycles in
//    SLOT_B only. When it reaches TIMEOUT-1 with !in_valid -> go HUNT,
//    locked<=0, no sync_err. A valid beat on that same cycle wins: the
//    counter clears and the beat is processed.
//  - SLOT_A has no timeout. Gaps between frames are legal; locked stays set.
//  - err_cnt increments on each sync_err and saturates at 2^ERRW-1. It clears
//    only on reset.
//  - locked: set only on a completed pair. Cleared on any sync_err or timeout.
//  - Gap (in_valid=0) in HUNT or SLOT_A: no change; strobes are 0.
//  - Reset mid-frame: immediate async clear, and the next frame must start
//    with sync. A partial A captured before reset is never paired.
//  - in_sync with !in_valid has no effect.
// STRUCTURE
//  - Shared include tdm_defs.vh holds the state encodings (HUNT=2'd0,
//    SLOT_B=2'd1, SLOT_A=2'd2) and the TIMEOUT/ERRW defaults. The future
//    tdm_mux2 transmitter uses the same file.
//  - One sub-module: sat_counter (parameter W; inc, clr; async active-low
//    reset), used for err_cnt. The idle counter stays inline.
//  - Top: FSM, data capture registers, strobe registers.
// TESTING
//  1 Reset: hold rst_n=0 and drive traffic -> all outputs 0. Release rst_n,
//    first beat is {sync=0} -> discarded, locked=0, sync_err=0.
//  2 Clean stream, WIDTH=1: (A=1,s),(B=0),(A=0,s),(B=1) back-to-back ->
//    pair_valid at cycles 2 and 4, out_a/out_b=1/0 then 0/1, locked=1 from
//    cycle 2.
//  3 Early sync: (A=1,s),(A=0,s),(B=1) -> sync_err at cycle 2, err_cnt=1,
//    the pair after is out_a=0/out_b=1, locked=1.
//  4 Missed sync while locked: pair, then (x, no sync) -> sync_err, locked=0,
//    HUNT. The next (A,s),(B) relocks.
//  5 Timeout: (A,s) then 8 idle cycles -> HUNT at idle 8 with no sync_err.
//    A B beat after that is discarded. Repeat with the B beat on idle cycle 8
//    -> the pair completes.
//  6 Saturation: ERRW=2 with 5 early syncs -> err_cnt stops at 3. Reset
//    mid-frame after (A,s) -> async clear, and no pair_valid on the following
//    (B).

Source files
------------

// File: rtl/tdm_demux2_pkg.sv
`default_nettype none
// ============================================================================
// Module : tdm_demux2_pkg
// Brief  : State encodings and parameter defaults shared by the 2-channel TDM
//          receiver (tdm_demux2) and the matching transmitter (tdm_mux2).
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package tdm_demux2_pkg;

  // Slot-tracking states. The encodings are fixed so both ends of the link
  // agree on them.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,   // searching for a sync-tagged A slot
    SLOT_B = 2'd1,   // A captured, next beat should be B
    SLOT_A = 2'd2    // pair complete, next beat should be a sync A
  } state_t;

  localparam int TIMEOUT_DEFAULT = 8;
  localparam int ERRW_DEFAULT    = 8;

endpackage : tdm_demux2_pkg
`default_nettype wire

// File: rtl/tdm_demux2_sat.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones. Synchronous clear, async
//          active-low reset.
// Ports  : clk    - rising-edge clock
//          rst_n  - asynchronous active-low reset
//          inc_i  - count one event this cycle
//          clr_i  - synchronous clear (has priority over inc_i)
//          cnt_o  - current count (W bits)
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter
  import tdm_demux2_pkg::*;
#(
  parameter int W = ERRW_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/tdm_demux2.sv
`default_nettype none
// ============================================================================
// Module : tdm_demux2
// Brief  : 2-channel TDM receiver. Splits an alternating A/B serial stream
//          (A slots tagged with sync) into two held, registered channel
//          outputs with strobes, and tracks frame lock and sync errors.
// Ports  : clk, rst_n            - clock, async active-low reset
//          in_data/in_valid/in_sync - incoming beat, sync marks an A slot
//          out_a/out_b           - last accepted A / B sample (held)
//          a_valid/b_valid       - 1-cycle update strobes
//          pair_valid            - out_a/out_b belong to one frame
//          locked                - frame alignment held
//          sync_err/err_cnt      - mismatch pulse and saturating count
// Rev    : 1.0  initial release
// ============================================================================
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ERRW    = ERRW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             a_valid,
  output logic             b_valid,
  output logic             pair_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [ERRW-1:0]  err_cnt
);

  // TIMEOUT is at most 255, so 8 bits always hold the idle count.
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t           state_q,  state_d;
  logic [7:0]       idle_q,   idle_d;
  logic [WIDTH-1:0] out_a_q,  out_a_d;
  logic [WIDTH-1:0] out_b_q,  out_b_d;
  logic             a_vld_q,  a_vld_d;
  logic             b_vld_q,  b_vld_d;
  logic             pair_q,   pair_d;
  logic             locked_q, locked_d;
  logic             serr_q,   serr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      idle_q   <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      pair_q   <= 1'b0;
      locked_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      pair_q   <= pair_d;
      locked_q <= locked_d;
      serr_q   <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    a_vld_d  = 1'b0;
    b_vld_d  = 1'b0;
    pair_d   = 1'b0;
    locked_d = locked_q;
    serr_d   = 1'b0;

    // Any accepted beat restarts the idle window, including a beat that
    // lands on the cycle the timeout would otherwise fire.
    if (in_valid) begin
      idle_d = '0;
    end

    case (state_q)
      HUNT: begin
        if (in_valid && in_sync) begin
          out_a_d = in_data;
          a_vld_d = 1'b1;
          state_d = SLOT_B;
        end
      end

      SLOT_B: begin
        if (in_valid) begin
          if (in_sync) begin
            // Early sync: the new beat restarts the frame as a fresh A.
            serr_d   = 1'b1;
            out_a_d  = in_data;
            a_vld_d  = 1'b1;
            locked_d = 1'b0;
          end else begin
            out_b_d  = in_data;
            b_vld_d  = 1'b1;
            pair_d   = 1'b1;
            locked_d = 1'b1;
            state_d  = SLOT_A;
          end
        end else if (idle_q == IDLE_LAST) begin
          // Half-received frame went stale: resynchronise silently.
          state_d  = HUNT;
          locked_d = 1'b0;
          idle_d   = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end

      SLOT_A: begin
        if (in_valid) begin
          if (in_sync) begin
            out_a_d = in_data;
            a_vld_d = 1'b1;
            state_d = SLOT_B;
          end else begin
            // Missed sync: alignment is lost, drop the beat.
            serr_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = HUNT;
          end
        end
      end

      default: begin
        state_d  = HUNT;
        locked_d = 1'b0;
      end
    endcase
  end

  // Fed from the next-state pulse so the count moves on the same cycle
  // that sync_err is seen.
  sat_counter #(
    .W (ERRW)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (serr_d),
    .clr_i (1'b0),
    .cnt_o (err_cnt)
  );

  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign a_valid    = a_vld_q;
  assign b_valid    = b_vld_q;
  assign pair_valid = pair_q;
  assign locked     = locked_q;
  assign sync_err   = serr_q;

endmodule : tdm_demux2
`default_nettype wire

// File: tb/tb_tdm_demux2.sv
`default_nettype none
// ============================================================================
// Module : tb_tdm_demux2
// Brief  : Self-checking bench for tdm_demux2. A table of per-cycle beats with
//          expected outputs is applied; completed pairs are also pushed to a
//          scoreboard queue and checked when pair_valid appears. A second
//          instance with ERRW=2 sees the same stream to check saturation.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tdm_demux2;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic       s;
    logic       d;
    logic [6:0] exp;   // {a_valid,b_valid,pair_valid,locked,sync_err,out_a,out_b}
    logic [7:0] ec;    // expected err_cnt for the ERRW=8 instance
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [0:0] in_data;
  logic       in_valid;
  logic       in_sync;

  logic [0:0] out_a, out_b;
  logic       a_valid, b_valid, pair_valid, locked, sync_err;
  logic [7:0] err_cnt;

  logic [0:0] out_a2, out_b2;
  logic       a_valid2, b_valid2, pair_valid2, locked2, sync_err2;
  logic [1:0] err_cnt2;

  int tests = 0;
  int fails = 0;

  vec_t       vecs[$];
  logic [1:0] pair_q[$];

  tdm_demux2 #(.WIDTH(1), .TIMEOUT(8), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sync(in_sync), .out_a(out_a), .out_b(out_b), .a_valid(a_valid),
    .b_valid(b_valid), .pair_valid(pair_valid), .locked(locked),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  tdm_demux2 #(.WIDTH(1), .TIMEOUT(8), .ERRW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sync(in_sync), .out_a(out_a2), .out_b(out_b2), .a_valid(a_valid2),
    .b_valid(b_valid2), .pair_valid(pair_valid2), .locked(locked2),
    .sync_err(sync_err2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic v, input logic s, input logic d,
                     input logic av, input logic bv, input logic pv, input logic lk,
                     input logic se, input logic oa, input logic ob, input int ec);
    vec_t t;
    t.rst_n = r; t.v = v; t.s = s; t.d = d;
    t.exp = {av, bv, pv, lk, se, oa, ob};
    t.ec  = 8'(ec);
    vecs.push_back(t);
  endtask

  // Scoreboard side: every pair_valid must match the oldest expected pair.
  always @(posedge clk) begin
    #2;
    if (pair_valid) begin
      tests++;
      if (pair_q.size() == 0) begin
        fails++;
        $display("FAIL pair_sb: got unexpected pair %b/%b, none expected", out_a, out_b);
      end else begin
        logic [1:0] e;
        e = pair_q.pop_front();
        if ({out_a, out_b} !== e) begin
          fails++;
          $display("FAIL pair_sb: got a/b=%b, need %b", {out_a, out_b}, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = 1'b0;

    // Reset held while traffic is present, then a non-sync first beat.
    add(0,1,1,1, 0,0,0,0,0,0,0, 0);
    add(0,1,0,1, 0,0,0,0,0,0,0, 0);
    add(1,1,0,1, 0,0,0,0,0,0,0, 0);
    // Clean stream (A=1,s)(B=0)(A=0,s)(B=1).
    add(1,1,1,1, 1,0,0,0,0,1,0, 0);
    add(1,1,0,0, 0,1,1,1,0,1,0, 0);
    add(1,1,1,0, 1,0,0,1,0,0,0, 0);
    add(1,1,0,1, 0,1,1,1,0,0,1, 0);
    // Gaps in SLOT_A, one with a stray sync: no effect.
    add(1,0,1,0, 0,0,0,1,0,0,1, 0);
    add(1,0,0,0, 0,0,0,1,0,0,1, 0);
    // Early sync.
    add(1,1,1,1, 1,0,0,1,0,1,1, 0);
    add(1,1,1,0, 1,0,0,0,1,0,1, 1);
    add(1,1,0,1, 0,1,1,1,0,0,1, 1);
    // Missed sync while locked, discard in HUNT, relock.
    add(1,1,0,1, 0,0,0,0,1,0,1, 2);
    add(1,1,0,0, 0,0,0,0,0,0,1, 2);
    add(1,1,1,1, 1,0,0,0,0,1,1, 2);
    add(1,1,0,0, 0,1,1,1,0,1,0, 2);
    // Timeout: A then 8 idle cycles; lock drops on the 8th, B then discarded.
    add(1,1,1,0, 1,0,0,1,0,0,0, 2);
    for (int i = 0; i < 7; i++) add(1,0,0,0, 0,0,0,1,0,0,0, 2);
    add(1,0,0,0, 0,0,0,0,0,0,0, 2);
    add(1,1,0,1, 0,0,0,0,0,0,0, 2);
    // B beat on the 8th idle slot wins over the timeout.
    add(1,1,1,1, 1,0,0,0,0,1,0, 2);
    for (int i = 0; i < 7; i++) add(1,0,(i == 3),0, 0,0,0,0,0,1,0, 2);
    add(1,1,0,1, 0,1,1,1,0,1,1, 2);
    // Five early syncs in a row (ERRW=2 instance saturates at 3).
    add(1,1,1,0, 1,0,0,1,0,0,1, 2);
    for (int i = 0; i < 5; i++) begin
      logic di;
      di = (i % 2 == 0);
      add(1,1,1,di, 1,0,0,0,1,di,1, 3 + i);
    end
    add(1,1,0,0, 0,1,1,1,0,1,0, 7);
    // Reset mid-frame after (A,s); the following B must not pair.
    add(1,1,1,0, 1,0,0,1,0,0,0, 7);
    add(0,0,0,0, 0,0,0,0,0,0,0, 0);
    add(1,1,0,1, 0,0,0,0,0,0,0, 0);
    add(1,1,1,1, 1,0,0,0,0,1,0, 0);
    add(1,1,0,0, 0,1,1,1,0,1,0, 0);

    foreach (vecs[k]) begin
      logic [6:0] act;
      logic [1:0] ec2;
      @(negedge clk);
      rst_n    = vecs[k].rst_n;
      in_valid = vecs[k].v;
      in_sync  = vecs[k].s;
      in_data  = vecs[k].d;
      if (vecs[k].exp[4]) pair_q.push_back(vecs[k].exp[1:0]);
      #1;
      // Reset must act without waiting for a clock edge.
      if (!vecs[k].rst_n) begin
        tests++;
        if ({a_valid, b_valid, pair_valid, locked, sync_err, out_a, out_b} !== 7'b0 ||
            err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
          fails++;
          $display("FAIL async_rst row%0d: got out=%b err=%0d err2=%0d, need all 0",
                   k, {a_valid, b_valid, pair_valid, locked, sync_err, out_a, out_b},
                   err_cnt, err_cnt2);
        end
      end
      @(posedge clk);
      #1;
      act = {a_valid, b_valid, pair_valid, locked, sync_err, out_a, out_b};
      tests++;
      if (act !== vecs[k].exp || err_cnt !== vecs[k].ec) begin
        fails++;
        $display("FAIL row%0d: got av,bv,pv,lk,se,a,b=%b err=%0d, need %b err=%0d",
                 k, act, err_cnt, vecs[k].exp, vecs[k].ec);
      end
      ec2 = (vecs[k].ec > 8'd3) ? 2'd3 : vecs[k].ec[1:0];
      tests++;
      if (err_cnt2 !== ec2 || locked2 !== vecs[k].exp[3]) begin
        fails++;
        $display("FAIL row%0d_errw2: got err=%0d lk=%b, need err=%0d lk=%b",
                 k, err_cnt2, locked2, ec2, vecs[k].exp[3]);
      end
    end

    // Drain: every expected pair must have been seen.
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (pair_q.size() != 0) begin
      fails++;
      $display("FAIL pair_drain: got %0d pairs never seen, need 0", pair_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_tdm_demux2
`default_nettype wire
